// File: rtl/rx_recv.sv
// rx_recv: UART receiver (8N1, optional even parity), LSB first, mid-bit sampling.
// Latency: about DW+1.5 bit periods from the start edge at rxs to valid (plus 2 sync cycles).
// Backpressure: one-entry output; a byte completing while valid=1 and ren=0 is dropped and pulses ovf.
//
// Ports:
//   CLK    clock, all logic on posedge
//   RST    synchronous active-high reset
//   RX     asynchronous serial line, idle high
//   ren    consumer accepts dout this cycle (ignored while valid=0)
//   dout   received byte, stable while valid=1
//   valid  dout holds an unread byte
//   ferr   1-cycle pulse: stop bit sampled 0
//   ovf    1-cycle pulse: byte discarded because the previous one was unread
//   perr   1-cycle pulse: parity mismatch (constant 0 unless RX_RECV_PARITY_EN)
//
// Build option: define RX_RECV_PARITY_EN to expect one even-parity bit between
// the data bits and the stop bit.

module rx_recv #(
   parameter int CLK_FREQ  = 10,
   parameter int BAUDRATE  = 9600,
   parameter int SLOOP_MAX = CLK_FREQ*1000*1000/BAUDRATE,
   parameter int DW        = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          RX,
   input  logic          ren,
   output logic [DW-1:0] dout,
   output logic          valid,
   output logic          ferr,
   output logic          ovf,
   output logic          perr
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   localparam logic [31:0] CNT_FULL  = 32'(SLOOP_MAX);
   localparam logic [31:0] CNT_HALF  = 32'(SLOOP_MAX / 2);
   localparam logic [4:0]  SCNT_LAST = 5'(DW - 1);

   state_t        state;
   logic [31:0]   cnt;
   logic [4:0]    scnt;
   logic [1:0]    rx_sync;
   logic [DW-1:0] shreg;
   logic          rxs;
   logic          cnt_zero;
   logic          par_ok;

   // Two-flop synchroniser output; every decision below looks only at this.
   assign rxs      = rx_sync[1];
   assign cnt_zero = (cnt == 32'd0);

`ifdef RX_RECV_PARITY_EN
   logic par_bit;

   // Even parity: data bits plus parity bit must XOR to zero.
   assign par_ok = ~(^{shreg, par_bit});
`else
   assign par_ok = 1'b1;
   assign perr   = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= 32'd0;
         scnt    <= 5'd0;
         rx_sync <= 2'b11;
         shreg   <= '0;
         dout    <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
`ifdef RX_RECV_PARITY_EN
         par_bit <= 1'b0;
         perr    <= 1'b0;
`endif
      end else begin
         rx_sync <= {rx_sync[0], RX};

         // Status outputs are single-cycle pulses.
         ferr <= 1'b0;
         ovf  <= 1'b0;
`ifdef RX_RECV_PARITY_EN
         perr <= 1'b0;
`endif

         // Consumer handshake; a delivery later in this block overrides the clear.
         if (valid && ren) begin
            valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxs) begin
                  // Wait half a bit so the start bit is re-checked at its centre.
                  state <= START;
                  cnt   <= CNT_HALF;
               end
            end

            START: begin
               if (cnt_zero) begin
                  if (rxs) begin
                     // Line went back high: treat as a glitch.
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     cnt   <= CNT_FULL;
                     scnt  <= 5'd0;
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end

            DATA: begin
               if (cnt_zero) begin
                  // Line order is LSB first, so shifting in at the MSB
                  // leaves bit 0 in shreg[0] after DW samples.
                  shreg <= {rxs, shreg[DW-1:1]};
                  scnt  <= scnt + 5'd1;
                  cnt   <= CNT_FULL;
                  if (scnt == SCNT_LAST) begin
`ifdef RX_RECV_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end

`ifdef RX_RECV_PARITY_EN
            PARITY: begin
               if (cnt_zero) begin
                  par_bit <= rxs;
                  cnt     <= CNT_FULL;
                  state   <= STOP;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
`endif

            STOP: begin
               if (cnt_zero) begin
`ifdef RX_RECV_PARITY_EN
                  perr <= ~par_ok;
`endif
                  if (!rxs) begin
                     // Framing error; hold off until the line returns high so a
                     // held-low line (break) cannot be mistaken for a start bit.
                     ferr  <= 1'b1;
                     state <= BREAK;
                  end else begin
                     state <= IDLE;
                     if (par_ok) begin
                        if (valid && !ren) begin
                           // Previous byte still unread: keep it, drop this one.
                           ovf <= 1'b1;
                        end else begin
                           dout  <= shreg;
                           valid <= 1'b1;
                        end
                     end
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end

            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_recv.sv
// tb_rx_recv: self-checking bench for rx_recv with SLOOP_MAX=7 (8 cycles per bit).
// Frames are generated bit by bit on RX; a behavioural model tracks the
// expected byte buffer, overrun and error pulse counts.

module tb_rx_recv;

   logic       CLK;
   logic       RST;
   logic       RX;
   logic       ren;
   logic [7:0] dout;
   logic       valid;
   logic       ferr;
   logic       ovf;
   logic       perr;

   int total = 0;
   int bad   = 0;

   // Observed pulse counts.
   int ferr_cnt = 0;
   int ovf_cnt  = 0;
   int perr_cnt = 0;

   // Behavioural model of the receive buffer and pulse counts.
   logic [7:0] m_dout  = 8'h00;
   bit         m_valid = 1'b0;
   int         m_ferr  = 0;
   int         m_ovf   = 0;
   int         m_perr  = 0;

   rx_recv #(
      .CLK_FREQ  (10),
      .BAUDRATE  (9600),
      .SLOOP_MAX (7),
      .DW        (8)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .RX    (RX),
      .ren   (ren),
      .dout  (dout),
      .valid (valid),
      .ferr  (ferr),
      .ovf   (ovf),
      .perr  (perr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (ferr === 1'b1) ferr_cnt++;
      if (ovf  === 1'b1) ovf_cnt++;
      if (perr === 1'b1) perr_cnt++;
   end

   // A complete frame reaches the receiver: decide what the consumer should see.
   function automatic void model_frame(input logic [7:0] b, input bit stop_ok,
                                       input bit par_ok, input bit ren_now);
      if (!stop_ok) m_ferr++;
      if (!par_ok)  m_perr++;
      if (stop_ok && par_ok) begin
         if (m_valid && !ren_now) begin
            m_ovf++;
         end else begin
            m_dout  = b;
            m_valid = 1'b1;
         end
      end
   endfunction

   function automatic void model_reset();
      m_dout  = 8'h00;
      m_valid = 1'b0;
   endfunction

   // Drive one frame, starting and ending on a negedge. With ren_at_stop, ren is
   // high at the stop-sample edge and the edge after it.
   task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                             input bit par_bad, input bit ren_at_stop);
      logic [11:0] bits;
      int          n;
      bits    = '0;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      n = 9;
`ifdef RX_RECV_PARITY_EN
      bits[9] = (^b) ^ par_bad;
      n = 10;
`endif
      bits[n] = stop_bit;
      for (int i = 0; i <= n; i++) begin
         RX = bits[i];
         if (i == n && ren_at_stop) begin
            repeat (6) @(negedge CLK);
            ren = 1'b1;
            repeat (2) @(negedge CLK);
            ren = 1'b0;
         end else begin
            repeat (8) @(negedge CLK);
         end
      end
   endtask

   task automatic wait_valid(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic read_byte();
      ren = 1'b1;
      @(negedge CLK);
      ren = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic test_reset();
      RX  = 1'b1;
      ren = 1'b0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      model_reset();
      @(negedge CLK);
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
      total++; if (ferr !== 1'b0)  begin bad++; $display("FAIL reset_ferr got=%b want=0", ferr); end
      total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
      total++; if (perr !== 1'b0)  begin bad++; $display("FAIL reset_perr got=%b want=0", perr); end
      repeat (16) @(negedge CLK);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL idle_no_false_start got=%b want=0", valid); end
   endtask

   task automatic test_single();
      bit ok;
      model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      wait_valid(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_valid_timeout got=0 want=1"); end
      total++; if (dout !== m_dout) begin bad++; $display("FAIL single_dout got=%h want=%h", dout, m_dout); end
      total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL single_ferr got=%0d want=%0d", ferr_cnt, m_ferr); end
      total++; if (ovf_cnt !== m_ovf) begin bad++; $display("FAIL single_ovf got=%0d want=%0d", ovf_cnt, m_ovf); end
      read_byte();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_ren_clear got=%b want=0", valid); end
      // ren while nothing is buffered must not change anything.
      read_byte();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL ren_idle got=%b want=0", valid); end
      total++; if (dout !== m_dout) begin bad++; $display("FAIL ren_idle_dout got=%h want=%h", dout, m_dout); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [6];
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      for (int i = 2; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
      fork
         begin
            for (int i = 0; i < 6; i++) send_frame(bytes[i], 1'b1, 1'b0, 1'b0);
         end
         begin
            bit ok;
            for (int i = 0; i < 6; i++) begin
               wait_valid(200, ok);
               total++;
               if (!ok) begin
                  bad++;
                  $display("FAIL b2b_timeout idx=%0d got=none want=%h", i, bytes[i]);
                  break;
               end
               if (dout !== bytes[i]) begin
                  bad++;
                  $display("FAIL b2b_dout idx=%0d got=%h want=%h", i, dout, bytes[i]);
               end
               read_byte();
            end
         end
      join
      m_dout  = bytes[5];
      m_valid = 1'b0;
      repeat (4) @(negedge CLK);
      total++; if (ovf_cnt !== m_ovf) begin bad++; $display("FAIL b2b_ovf got=%0d want=%0d", ovf_cnt, m_ovf); end
      total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL b2b_ferr got=%0d want=%0d", ferr_cnt, m_ferr); end
   endtask

   task automatic test_glitch();
      RX = 1'b0;
      repeat (2) @(negedge CLK);
      RX = 1'b1;
      repeat (40) @(negedge CLK);
      total++; if (valid !== m_valid) begin bad++; $display("FAIL glitch_valid got=%b want=%b", valid, m_valid); end
      total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL glitch_ferr got=%0d want=%0d", ferr_cnt, m_ferr); end
   endtask

   task automatic test_break();
      bit ok;
      model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      RX = 1'b0;
      repeat (40) @(negedge CLK);
      RX = 1'b1;
      repeat (16) @(negedge CLK);
      total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL break_ferr got=%0d want=%0d", ferr_cnt, m_ferr); end
      total++; if (valid !== m_valid) begin bad++; $display("FAIL break_valid got=%b want=%b", valid, m_valid); end
      model_frame(8'h81, 1'b1, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      wait_valid(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL after_break_timeout got=0 want=1"); end
      total++; if (dout !== m_dout) begin bad++; $display("FAIL after_break_dout got=%h want=%h", dout, m_dout); end
      read_byte();
   endtask

   task automatic test_overrun();
      model_frame(8'h11, 1'b1, 1'b1, 1'b0);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      model_frame(8'h22, 1'b1, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge CLK);
      total++; if (ovf_cnt !== m_ovf) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", ovf_cnt, m_ovf); end
      total++; if (dout !== m_dout) begin bad++; $display("FAIL ovf_dout_kept got=%h want=%h", dout, m_dout); end
      total++; if (valid !== m_valid) begin bad++; $display("FAIL ovf_valid got=%b want=%b", valid, m_valid); end
      // Same situation, but the consumer reads on the delivery edge.
      model_frame(8'h22, 1'b1, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1);
      repeat (2) @(negedge CLK);
      total++; if (dout !== m_dout) begin bad++; $display("FAIL ren_coincide_dout got=%h want=%h", dout, m_dout); end
      total++; if (ovf_cnt !== m_ovf) begin bad++; $display("FAIL ren_coincide_ovf got=%0d want=%0d", ovf_cnt, m_ovf); end
      read_byte();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL ren_coincide_clear got=%b want=0", valid); end
   endtask

   task automatic test_reset_mid();
      bit         ok;
      logic [7:0] b;
      b  = 8'h5A;
      RX = 1'b0;
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         RX = b[i];
         repeat (8) @(negedge CLK);
      end
      RST = 1'b1;
      RX  = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      total++; if (dout !== m_dout) begin bad++; $display("FAIL midreset_dout got=%h want=%h", dout, m_dout); end
      total++; if (valid !== m_valid) begin bad++; $display("FAIL midreset_valid got=%b want=%b", valid, m_valid); end
      repeat (30) @(negedge CLK);
      total++; if (valid !== m_valid) begin bad++; $display("FAIL midreset_partial_drop got=%b want=%b", valid, m_valid); end
      model_frame(8'hC3, 1'b1, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
      wait_valid(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL midreset_timeout got=0 want=1"); end
      total++; if (dout !== m_dout) begin bad++; $display("FAIL midreset_dout_c3 got=%h want=%h", dout, m_dout); end
      read_byte();
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         bad_stop;
      bit         par_bad;
      for (int it = 0; it < 10; it++) begin
         b        = 8'($urandom_range(0, 255));
         bad_stop = ($urandom_range(0, 3) == 0);
         par_bad  = 1'b0;
`ifdef RX_RECV_PARITY_EN
         par_bad  = ($urandom_range(0, 3) == 0);
`endif
         model_frame(b, !bad_stop, !par_bad, 1'b0);
         send_frame(b, !bad_stop, par_bad, 1'b0);
         RX = 1'b1;
         repeat (12) @(negedge CLK);
         total++; if (valid !== m_valid) begin bad++; $display("FAIL rnd_valid it=%0d got=%b want=%b", it, valid, m_valid); end
         total++; if (dout !== m_dout) begin bad++; $display("FAIL rnd_dout it=%0d got=%h want=%h", it, dout, m_dout); end
         total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL rnd_ferr it=%0d got=%0d want=%0d", it, ferr_cnt, m_ferr); end
         total++; if (perr_cnt !== m_perr) begin bad++; $display("FAIL rnd_perr it=%0d got=%0d want=%0d", it, perr_cnt, m_perr); end
         if (valid === 1'b1) read_byte();
      end
   endtask

`ifdef RX_RECV_PARITY_EN
   task automatic test_parity();
      model_frame(8'h07, 1'b1, 1'b0, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      RX = 1'b1;
      repeat (4) @(negedge CLK);
      total++; if (perr_cnt !== m_perr) begin bad++; $display("FAIL parity_perr got=%0d want=%0d", perr_cnt, m_perr); end
      total++; if (valid !== m_valid) begin bad++; $display("FAIL parity_valid got=%b want=%b", valid, m_valid); end
      total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL parity_ferr got=%0d want=%0d", ferr_cnt, m_ferr); end
   endtask
`endif

   initial begin
      RST = 1'b1;
      RX  = 1'b1;
      ren = 1'b0;
      @(negedge CLK);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_break();
      test_overrun();
      test_reset_mid();
      test_random();
`ifdef RX_RECV_PARITY_EN
      test_parity();
`endif
      repeat (4) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
